// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default constants for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int unsigned FETCH_XLEN_DEFAULT = 32;
    localparam logic [FETCH_XLEN_DEFAULT-1:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;

    // One queued fetch: the instruction word, its address and the fall-through address.
    typedef struct packed {
        logic [FETCH_XLEN_DEFAULT-1:0] instr;
        logic [FETCH_XLEN_DEFAULT-1:0] pc;
        logic [FETCH_XLEN_DEFAULT-1:0] pc4;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Circular buffer of fetch entries with push, pop and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         ENTRY_T = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ENTRY_T                 wr_entry,
    output ENTRY_T                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    ENTRY_T        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Sequential instruction fetch with redirect and decode queue.
//               Optional performance counters: define FETCH_PERF_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [XLEN-1:0]        deq_instr,
    output logic [XLEN-1:0]        deq_pc,
    output logic [XLEN-1:0]        deq_pc4,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [XLEN-1:0]        perf_fetch_cnt,
    output logic [XLEN-1:0]        perf_flush_cnt,
    output logic [XLEN-1:0]        perf_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } entry_t;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  fetch_pc4;
    logic             push, pop, full;
    logic [CNT_W-1:0] count;
    entry_t           wr_entry, head_entry;

    assign fetch_pc4 = fetch_pc_q + XLEN'(4);
    assign full      = (count == CNT_W'(DEPTH));
    assign deq_valid = (count != '0);

    // A full queue may still accept the new word when the head leaves this cycle.
    assign push = !redirect_valid && (!full || (deq_valid && deq_ready));
    assign pop  = deq_valid && deq_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign wr_entry = '{instr: imem_data, pc: fetch_pc_q, pc4: fetch_pc4};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head_entry),
        .count    (count)
    );

    assign imem_addr = fetch_pc_q;
    assign deq_instr = head_entry.instr;
    assign deq_pc    = head_entry.pc;
    assign deq_pc4   = head_entry.pc4;
    assign occupancy = count;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push && (fetch_cnt_q != '1))           fetch_cnt_d = fetch_cnt_q + 1'b1;
        if (redirect_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        if (full && !pop && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
